// File: rtl/cam_lvds_align.sv
`default_nettype none
// ============================================================================
//  Module      : cam_lvds_align
//  Description : Word-alignment trainer for the camera LVDS deserializer.
//                One FSM per channel issues bitslip pulses until each channel
//                shows TRAIN_PATTERN for MATCH_COUNT consecutive words, then
//                reports aligned/fail status and forwards registered words.
//  Options     : CAM_ALIGN_SLIPCNT_EN - when defined, slip_cnt reports live
//                per-channel 5-bit bitslip counts; otherwise slip_cnt is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_lvds_align #(
    parameter int               NUM_CH        = 5,
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 8'h3A,
    parameter int               SETTLE_CYC    = 4,
    parameter int               MATCH_COUNT   = 16,
    parameter int               MAX_SLIPS     = 16
) (
    input  logic                      c,
    input  logic                      rst,
    input  logic                      train,
    input  logic                      pll_locked,
    input  logic [NUM_CH*WIDTH-1:0]   rxd,
    output logic [NUM_CH-1:0]         bitslip,
    output logic [NUM_CH-1:0]         aligned,
    output logic                      all_aligned,
    output logic [NUM_CH-1:0]         fail,
    output logic [NUM_CH*WIDTH-1:0]   dout,
    output logic                      dout_valid,
    output logic [NUM_CH*5-1:0]       slip_cnt
);

    localparam int c_SETTLE_W = $clog2(SETTLE_CYC + 1);
    localparam int c_MATCH_W  = $clog2(MATCH_COUNT + 1);
`ifdef CAM_ALIGN_SLIPCNT_EN
    // Full 5-bit reporting counter, saturating at its maximum.
    localparam int c_SLIP_W   = 5;
    localparam int c_SLIP_SAT = 31;
`else
    // Only enough bits to recognise the slip budget.
    localparam int c_SLIP_W   = $clog2(MAX_SLIPS + 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    logic                    r_train_meta;
    logic                    r_train_s;
    logic                    r_lock_meta;
    logic                    r_lock_s;
    logic                    w_go;
    logic                    r_all_aligned;
    logic [NUM_CH*WIDTH-1:0] r_dout;
    logic [NUM_CH-1:0]       w_aligned;

    // Two-flop synchronizers for the asynchronous train request and PLL lock.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_train_meta <= 1'b0;
            r_train_s    <= 1'b0;
            r_lock_meta  <= 1'b0;
            r_lock_s     <= 1'b0;
        end else begin
            r_train_meta <= train;
            r_train_s    <= r_train_meta;
            r_lock_meta  <= pll_locked;
            r_lock_s     <= r_lock_meta;
        end
    end

    assign w_go = r_train_s & r_lock_s;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            state_t                r_state;
            logic [c_SETTLE_W-1:0] r_settle;
            logic [c_MATCH_W-1:0]  r_match;
            logic [c_SLIP_W-1:0]   r_slips;
            logic                  r_bitslip;
            logic                  r_aligned;
            logic                  r_fail;
            logic [WIDTH-1:0]      w_word;

            assign w_word = rxd[k*WIDTH +: WIDTH];

            // Per-channel training FSM; losing go from any state returns to IDLE.
            always_ff @(posedge c or posedge rst) begin
                if (rst) begin
                    r_state   <= ST_IDLE;
                    r_settle  <= '0;
                    r_match   <= '0;
                    r_slips   <= '0;
                    r_bitslip <= 1'b0;
                    r_aligned <= 1'b0;
                    r_fail    <= 1'b0;
                end else if (!w_go) begin
                    r_state   <= ST_IDLE;
                    r_settle  <= '0;
                    r_match   <= '0;
                    r_slips   <= '0;
                    r_bitslip <= 1'b0;
                    r_aligned <= 1'b0;
                    r_fail    <= 1'b0;
                end else begin
                    // Bitslip is a single-cycle pulse raised only on entry to SLIP.
                    r_bitslip <= 1'b0;
                    case (r_state)
                        ST_IDLE: begin
                            r_settle  <= '0;
                            r_match   <= '0;
                            r_slips   <= '0;
                            r_aligned <= 1'b0;
                            r_fail    <= 1'b0;
                            r_state   <= ST_SETTLE;
                        end
                        ST_SETTLE: begin
                            // Let the deserializer's bitslip pipeline drain before comparing.
                            if (r_settle == c_SETTLE_W'(SETTLE_CYC - 1)) begin
                                r_settle <= '0;
                                r_state  <= ST_CHECK;
                            end else begin
                                r_settle <= r_settle + 1'b1;
                            end
                        end
                        ST_CHECK: begin
                            if (w_word == TRAIN_PATTERN) begin
                                r_match <= r_match + 1'b1;
                                if (r_match == c_MATCH_W'(MATCH_COUNT - 1)) begin
                                    r_state   <= ST_LOCKED;
                                    r_aligned <= 1'b1;
                                end
                            end else begin
                                r_match <= '0;
                                if (r_slips == c_SLIP_W'(MAX_SLIPS)) begin
                                    r_state <= ST_FAIL;
                                    r_fail  <= 1'b1;
                                end else begin
                                    r_state   <= ST_SLIP;
                                    r_bitslip <= 1'b1;
`ifdef CAM_ALIGN_SLIPCNT_EN
                                    if (r_slips != c_SLIP_W'(c_SLIP_SAT)) begin
                                        r_slips <= r_slips + 1'b1;
                                    end
`else
                                    r_slips <= r_slips + 1'b1;
`endif
                                end
                            end
                        end
                        ST_SLIP: begin
                            r_state <= ST_SETTLE;
                        end
                        ST_LOCKED: begin
                            // Image data after lock is ignored; hold until go drops.
                            r_aligned <= 1'b1;
                        end
                        ST_FAIL: begin
                            r_fail <= 1'b1;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end

            assign bitslip[k]   = r_bitslip;
            assign w_aligned[k] = r_aligned;
            assign fail[k]      = r_fail;
`ifdef CAM_ALIGN_SLIPCNT_EN
            assign slip_cnt[k*5 +: 5] = r_slips;
`endif
        end
    endgenerate

`ifndef CAM_ALIGN_SLIPCNT_EN
    assign slip_cnt = '0;
`endif

    // Output pipeline: data delayed one cycle, aggregate aligned flag registered.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_dout        <= '0;
            r_all_aligned <= 1'b0;
        end else begin
            r_dout        <= rxd;
            r_all_aligned <= &w_aligned;
        end
    end

    assign aligned     = w_aligned;
    assign all_aligned = r_all_aligned;
    assign dout        = r_dout;
    assign dout_valid  = r_all_aligned;

endmodule
`default_nettype wire

// File: tb/tb_cam_lvds_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_lvds_align
//  Description : Directed self-checking bench for cam_lvds_align. A channel
//                model rotates TRAIN_PATTERN and undoes one bit of rotation
//                per observed bitslip pulse. Honours CAM_ALIGN_SLIPCNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_lvds_align;

    localparam int NCH = 5;
    localparam int W   = 8;

    logic              c;
    logic              rst;
    logic              train;
    logic              pll_locked;
    logic [NCH*W-1:0]  rxd;
    logic [NCH-1:0]    bitslip;
    logic [NCH-1:0]    aligned;
    logic              all_aligned;
    logic [NCH-1:0]    fail;
    logic [NCH*W-1:0]  dout;
    logic              dout_valid;
    logic [NCH*5-1:0]  slip_cnt;

    int                n_pass;
    int                n_total;

    // Channel model state
    int                pulses  [NCH];
    int                applied [NCH];
    int                p0      [NCH];
    logic [2:0]        rot_init[NCH];
    logic              force_en[NCH];
    logic [7:0]        force_val[NCH];
    logic              slip_ignore[NCH];

    cam_lvds_align dut (
        .c           (c),
        .rst         (rst),
        .train       (train),
        .pll_locked  (pll_locked),
        .rxd         (rxd),
        .bitslip     (bitslip),
        .aligned     (aligned),
        .all_aligned (all_aligned),
        .fail        (fail),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .slip_cnt    (slip_cnt)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Each sampled bitslip pulse removes one bit of rotation on that channel.
    always @(posedge c) begin
        for (int k = 0; k < NCH; k++) begin
            if (bitslip[k] === 1'b1) begin
                pulses[k] <= pulses[k] + 1;
                if (!slip_ignore[k]) applied[k] <= applied[k] + 1;
            end
        end
    end

    always_comb begin
        rxd = '0;
        for (int k = 0; k < NCH; k++) begin
            rxd[k*W +: W] = force_en[k] ? force_val[k]
                                        : rotl8(8'h3A, rot_init[k] - 3'(applied[k]));
        end
    end

    function automatic int pdiff(input int k);
        return pulses[k] - p0[k];
    endfunction

    function automatic int pother(input int skip);
        int s;
        s = 0;
        for (int k = 0; k < NCH; k++) if (k != skip) s += pulses[k] - p0[k];
        return s;
    endfunction

    task automatic snap();
        for (int k = 0; k < NCH; k++) p0[k] = pulses[k];
    endtask

    task automatic set_rot(input int k, input int r);
        rot_init[k] = 3'(r + applied[k]);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge c);
    endtask

    initial begin
        logic found;
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1; train = 1'b0; pll_locked = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            rot_init[k] = 3'd0; force_en[k] = 1'b0; force_val[k] = 8'h00;
            slip_ignore[k] = 1'b0; p0[k] = 0;
        end
        cyc(3);

        // Reset state
        chk("rst_bitslip",     bitslip,     5'h00);
        chk("rst_aligned",     aligned,     5'h00);
        chk("rst_fail",        fail,        5'h00);
        chk("rst_all_aligned", all_aligned, 1'b0);
        chk("rst_dout",        dout,        40'h0);
        chk("rst_dout_valid",  dout_valid,  1'b0);
        chk("rst_slip_cnt",    slip_cnt,    25'h0);
        rst = 1'b0;
        cyc(4);

        // T1: all channels already aligned; aligned 23 edges after train
        snap();
        train = 1'b1;
        cyc(22);
        chk("t1_aligned_early", aligned, 5'h00);
        cyc(1);
        chk("t1_aligned",       aligned, 5'h1F);
        chk("t1_all_early",     all_aligned, 1'b0);
        cyc(1);
        chk("t1_all_aligned",   all_aligned, 1'b1);
        chk("t1_dout_valid",    dout_valid, 1'b1);
        chk("t1_dout",          dout, 40'h3A3A3A3A3A);
        chk("t1_pulses",        pother(-1), 0);
        chk("t1_slip_cnt",      slip_cnt, 25'h0);

        // T2: channel 2 rotated by 3 -> three pulses on ch2
        train = 1'b0;
        cyc(4);
        chk("t2_idle_aligned",  aligned, 5'h00);
        chk("t2_idle_valid",    dout_valid, 1'b0);
        set_rot(2, 3);
        snap();
        train = 1'b1;
        cyc(40);
        chk("t2_aligned_early", aligned, 5'h1B);
        cyc(1);
        chk("t2_aligned",       aligned, 5'h1F);
        chk("t2_ch2_pulses",    pdiff(2), 3);
        chk("t2_other_pulses",  pother(2), 0);
`ifdef CAM_ALIGN_SLIPCNT_EN
        chk("t2_slip_cnt",      slip_cnt, 25'd3 << 10);
`else
        chk("t2_slip_cnt",      slip_cnt, 25'h0);
`endif

        // T3: channel 4 never matches -> 16 pulses then fail
        train = 1'b0;
        cyc(4);
        set_rot(2, 0);
        force_en[4] = 1'b1; force_val[4] = 8'h00;
        snap();
        train = 1'b1;
        cyc(103);
        chk("t3_fail_early",    fail, 5'h00);
        chk("t3_ch4_pulses",    pdiff(4), 16);
        cyc(1);
        chk("t3_fail",          fail, 5'h10);
        chk("t3_aligned",       aligned, 5'h0F);
        cyc(2);
        chk("t3_all_aligned",   all_aligned, 1'b0);
        chk("t3_dout_valid",    dout_valid, 1'b0);
        chk("t3_ch4_pulses_end", pdiff(4), 16);
        chk("t3_other_pulses",  pother(4), 0);
`ifdef CAM_ALIGN_SLIPCNT_EN
        chk("t3_slip_cnt",      slip_cnt, 25'd16 << 20);
`else
        chk("t3_slip_cnt",      slip_cnt, 25'h0);
`endif

        // T4: single bad word on ch0 after 10 matches -> one pulse, full rerun
        train = 1'b0;
        cyc(4);
        chk("t4_fail_cleared",  fail, 5'h00);
        force_en[4] = 1'b0;
        slip_ignore[0] = 1'b1;
        snap();
        train = 1'b1;
        cyc(17);
        force_en[0] = 1'b1; force_val[0] = 8'hFF;
        cyc(1);
        chk("t4_dout_glitch",   dout[7:0], 8'hFF);
        force_en[0] = 1'b0;
        cyc(20);
        chk("t4_aligned_early", aligned, 5'h1E);
        cyc(1);
        chk("t4_aligned",       aligned, 5'h1F);
        chk("t4_ch0_pulses",    pdiff(0), 1);
        chk("t4_other_pulses",  pother(0), 0);
`ifdef CAM_ALIGN_SLIPCNT_EN
        chk("t4_slip_cnt",      slip_cnt, 25'd1);
`else
        chk("t4_slip_cnt",      slip_cnt, 25'h0);
`endif

        // T5a: PLL lock lost during SETTLE, then restored
        slip_ignore[0] = 1'b0;
        train = 1'b0;
        cyc(4);
        snap();
        train = 1'b1;
        cyc(4);
        pll_locked = 1'b0;
        cyc(3);
        chk("t5a_aligned",      aligned, 5'h00);
        chk("t5a_bitslip",      bitslip, 5'h00);
        chk("t5a_dout_valid",   dout_valid, 1'b0);
        pll_locked = 1'b1;
        cyc(22);
        chk("t5a_relock_early", aligned, 5'h00);
        cyc(1);
        chk("t5a_relock",       aligned, 5'h1F);

        // T5b: PLL lock lost while LOCKED
        cyc(3);
        chk("t5b_valid_before", dout_valid, 1'b1);
        pll_locked = 1'b0;
        cyc(2);
        chk("t5b_aligned_hold", aligned, 5'h1F);
        cyc(1);
        chk("t5b_aligned_drop", aligned, 5'h00);
        cyc(1);
        chk("t5b_all_aligned",  all_aligned, 1'b0);
        chk("t5b_dout_valid",   dout_valid, 1'b0);

        // T6: asynchronous reset while ch1 is in SLIP
        set_rot(1, 2);
        pll_locked = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge c);
            if (bitslip[1] === 1'b1) found = 1'b1;
        end
        chk("t6_slip_seen",     found, 1'b1);
        chk("t6_bitslip_high",  bitslip, 5'h02);
        #1 rst = 1'b1;
        #1;
        chk("t6_bitslip_async", bitslip, 5'h00);
        chk("t6_dout_async",    dout, 40'h0);
        chk("t6_slip_cnt",      slip_cnt, 25'h0);
        chk("t6_fail",          fail, 5'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
